// File: rtl/sysbus_arbiter_if.sv
// sysbus_arbiter_if: Sysbus request/response channel; master drives reqcyc/req/reqtag/respack, slave drives reqack/respcyc/resp/resptag
interface sysbus_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 13
);
    logic                  reqcyc;
    logic [DATA_WIDTH-1:0] req;
    logic [TAG_WIDTH-1:0]  reqtag;
    logic                  reqack;
    logic                  respcyc;
    logic [DATA_WIDTH-1:0] resp;
    logic [TAG_WIDTH-1:0]  resptag;
    logic                  respack;
    modport master (output reqcyc, req, reqtag, respack, input reqack, respcyc, resp, resptag);
    modport slave  (input reqcyc, req, reqtag, respack, output reqack, respcyc, resp, resptag);
endinterface

// File: rtl/sysbus_arbiter.sv
// sysbus_arbiter: round-robin whole-transaction arbiter of fetch (f) and data (d) requesters onto one Sysbus master (bus); ports clk, reset (async), f/d slave channels, bus master channel, proto_err pulse
module sysbus_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 13,
    parameter int BEATS      = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    sysbus_arbiter_if.slave         f,
    sysbus_arbiter_if.slave         d,
    sysbus_arbiter_if.master        bus,
    output logic                    proto_err
);
    localparam int BW = $clog2(BEATS) + 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    typedef enum logic [1:0] {IDLE, REQ, WDATA, RESP} state_t;
    state_t                  state, state_n;
    logic                    owner, owner_n, last, last_n, is_write, is_write_n;
    logic [BW-1:0]           beat, beat_n;
    logic                    gd, adv, in_req, in_fwd, in_resp;
    logic                    o_reqcyc, o_respack;
    logic [DATA_WIDTH-1:0]   o_req;
    logic [TAG_WIDTH-1:0]    o_reqtag;
    assign o_reqcyc  = owner ? d.reqcyc  : f.reqcyc;
    assign o_req     = owner ? d.req     : f.req;
    assign o_reqtag  = owner ? d.reqtag  : f.reqtag;
    assign o_respack = owner ? d.respack : f.respack;
    assign in_req  = state == REQ;
    assign in_fwd  = in_req || state == WDATA;
    assign in_resp = state == RESP;
    // d wins when it is alone, or on a tie when f was granted last
    assign gd  = d.reqcyc && (!f.reqcyc || !last);
    assign adv = (state == WDATA && o_reqcyc) || (in_resp && bus.respcyc && o_respack);
    always_comb begin
        state_n    = state;
        owner_n    = owner;
        last_n     = last;
        is_write_n = is_write;
        beat_n     = beat;
        if (state == IDLE && (f.reqcyc || d.reqcyc)) begin
            owner_n    = gd;
            last_n     = gd;
            is_write_n = ~(gd ? d.reqtag[TAG_WIDTH-1] : f.reqtag[TAG_WIDTH-1]);
            state_n    = REQ;
        end
        if (in_req && bus.reqack) begin
            state_n = is_write ? WDATA : RESP;
            beat_n  = '0;
        end
        if (adv) begin
            beat_n  = beat == LAST_BEAT ? '0 : beat + 1'b1;
            state_n = beat == LAST_BEAT ? IDLE : state;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= 1'b0;
            last      <= 1'b1;
            is_write  <= 1'b0;
            beat      <= '0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            last      <= last_n;
            is_write  <= is_write_n;
            beat      <= beat_n;
            proto_err <= bus.respcyc && !in_resp;
        end
    end
    assign bus.reqcyc  = in_fwd && o_reqcyc;
    assign bus.req     = in_fwd ? o_req : '0;
    assign bus.reqtag  = in_fwd ? o_reqtag : '0;
    assign bus.respack = in_resp && o_respack;
    assign f.reqack    = in_req && !owner && bus.reqack;
    assign d.reqack    = in_req && owner && bus.reqack;
    assign f.respcyc   = in_resp && !owner && bus.respcyc;
    assign d.respcyc   = in_resp && owner && bus.respcyc;
    assign f.resp      = in_resp ? bus.resp : '0;
    assign d.resp      = in_resp ? bus.resp : '0;
    assign f.resptag   = in_resp ? bus.resptag : '0;
    assign d.resptag   = in_resp ? bus.resptag : '0;
endmodule

// File: tb/tb_sysbus_arbiter.sv
// tb_sysbus_arbiter: directed self-checking bench for sysbus_arbiter
module tb_sysbus_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic proto_err;
    int n_cmp = 0;
    int n_bad = 0;
    localparam logic [12:0] RD = 13'h1000;
    sysbus_arbiter_if #(.DATA_WIDTH(64), .TAG_WIDTH(13)) f_if ();
    sysbus_arbiter_if #(.DATA_WIDTH(64), .TAG_WIDTH(13)) d_if ();
    sysbus_arbiter_if #(.DATA_WIDTH(64), .TAG_WIDTH(13)) bus_if ();
    sysbus_arbiter #(.DATA_WIDTH(64), .TAG_WIDTH(13), .BEATS(8)) dut (
        .clk(clk),
        .reset(reset),
        .f(f_if),
        .d(d_if),
        .bus(bus_if),
        .proto_err(proto_err)
    );
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic set_req(input logic who, input logic v, input logic [63:0] a, input logic [12:0] t);
        if (who) begin
            d_if.reqcyc = v; d_if.req = a; d_if.reqtag = t;
        end else begin
            f_if.reqcyc = v; f_if.req = a; f_if.reqtag = t;
        end
    endtask
    task automatic set_respack(input logic who, input logic v);
        if (who) d_if.respack = v;
        else f_if.respack = v;
    endtask
    // entered one cycle after the grant edge; acks one cycle late, then takes 8 read beats
    task automatic serve_read(input logic who, input logic [63:0] a, input logic [63:0] base, input int stall_at);
        int k = 0;
        int stalls = 0;
        int guard = 0;
        logic ack;
        #1;
        chk("req_cyc", bus_if.reqcyc, 1);
        chk("req_addr", bus_if.req, a);
        chk("ack_hold", who ? d_if.reqack : f_if.reqack, 0);
        cyc();
        bus_if.reqack = 1;
        #1;
        chk("own_ack", who ? d_if.reqack : f_if.reqack, 1);
        chk("other_ack", who ? f_if.reqack : d_if.reqack, 0);
        cyc();
        bus_if.reqack = 0;
        set_req(who, 0, 0, 0);
        while (k < 8 && guard < 40) begin
            guard++;
            ack = !(k == stall_at && stalls < 3);
            bus_if.respcyc = 1;
            bus_if.resp = base + 64'(k);
            bus_if.resptag = RD;
            set_respack(who, ack);
            #1;
            chk("own_respcyc", who ? d_if.respcyc : f_if.respcyc, 1);
            chk("other_respcyc", who ? f_if.respcyc : d_if.respcyc, 0);
            chk("resp_data", who ? d_if.resp : f_if.resp, base + 64'(k));
            chk("bus_respack", bus_if.respack, ack);
            if (!ack) begin
                stalls++;
                chk("beat_frozen", dut.beat, k);
            end else k++;
            cyc();
        end
        bus_if.respcyc = 0;
        set_respack(who, 0);
        chk("beats_delivered", k, 8);
        #1;
        chk("idle_after", dut.state, 0);
    endtask
    initial begin
        f_if.reqcyc = 0; f_if.req = 0; f_if.reqtag = 0; f_if.respack = 0;
        d_if.reqcyc = 0; d_if.req = 0; d_if.reqtag = 0; d_if.respack = 0;
        bus_if.reqack = 0; bus_if.respcyc = 0; bus_if.resp = 0; bus_if.resptag = 0;
        #1 reset = 1;
        #1;
        chk("rst_bus_reqcyc", bus_if.reqcyc, 0);
        chk("rst_bus_respack", bus_if.respack, 0);
        chk("rst_proto_err", proto_err, 0);
        chk("rst_state", dut.state, 0);
        repeat (2) @(posedge clk);
        #1 reset = 0;
        // single read from f
        set_req(0, 1, 64'h1000, RD);
        #1 chk("grant_latency", bus_if.reqcyc, 0);
        cyc();
        serve_read(0, 64'h1000, 64'h0, -1);
        // simultaneous reads from reset: f, then d wins the second tie, then f
        reset = 1;
        #2 reset = 0;
        set_req(0, 1, 64'h3000, RD);
        set_req(1, 1, 64'h4000, RD | 13'h1);
        cyc();
        serve_read(0, 64'h3000, 64'h30, -1);
        set_req(0, 1, 64'h3100, RD);
        cyc();
        serve_read(1, 64'h4000, 64'h40, -1);
        cyc();
        serve_read(0, 64'h3100, 64'h31, -1);
        // d write with f pending throughout
        set_req(1, 1, 64'h2000, 13'h0005);
        set_req(0, 1, 64'h5000, RD);
        cyc();
        #1;
        chk("wr_addr", bus_if.req, 64'h2000);
        chk("wr_tag", bus_if.reqtag, 64'h5);
        bus_if.reqack = 1;
        #1;
        chk("wr_d_ack", d_if.reqack, 1);
        chk("wr_f_ack", f_if.reqack, 0);
        cyc();
        bus_if.reqack = 0;
        for (int i = 0; i < 8; i++) begin
            d_if.req = 64'hA0 + 64'(i);
            d_if.reqcyc = 1;
            #1;
            chk("wr_cyc", bus_if.reqcyc, 1);
            chk("wr_data", bus_if.req, 64'hA0 + 64'(i));
            chk("wr_no_resp", d_if.respcyc, 0);
            cyc();
        end
        set_req(1, 0, 0, 0);
        #1;
        chk("wr_idle", dut.state, 0);
        chk("wr_gap", bus_if.reqcyc, 0);
        cyc();
        // pending f read, with response backpressure at beat 3
        serve_read(0, 64'h5000, 64'h50, 3);
        // stray response while idle
        bus_if.respcyc = 1;
        bus_if.resp = 64'hDEAD;
        #1;
        chk("stray_respack", bus_if.respack, 0);
        chk("stray_f_respcyc", f_if.respcyc, 0);
        chk("stray_d_respcyc", d_if.respcyc, 0);
        chk("stray_err_early", proto_err, 0);
        cyc();
        bus_if.respcyc = 0;
        chk("stray_err_pulse", proto_err, 1);
        chk("stray_state", dut.state, 0);
        cyc();
        chk("stray_err_end", proto_err, 0);
        // async reset during RESP beat 4
        set_req(0, 1, 64'h6000, RD);
        cyc();
        bus_if.reqack = 1;
        cyc();
        bus_if.reqack = 0;
        set_req(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            bus_if.respcyc = 1;
            bus_if.resp = 64'(i);
            f_if.respack = 1;
            cyc();
        end
        bus_if.resp = 64'h4;
        #1;
        chk("pre_rst_beat", dut.beat, 4);
        chk("pre_rst_respcyc", f_if.respcyc, 1);
        #1 reset = 1;
        #1;
        chk("arst_f_respcyc", f_if.respcyc, 0);
        chk("arst_f_resp", f_if.resp, 0);
        chk("arst_bus_respack", bus_if.respack, 0);
        chk("arst_bus_reqcyc", bus_if.reqcyc, 0);
        chk("arst_state", dut.state, 0);
        chk("arst_beat", dut.beat, 0);
        bus_if.respcyc = 0;
        f_if.respack = 0;
        cyc();
        reset = 0;
        set_req(0, 1, 64'h7000, RD);
        cyc();
        serve_read(0, 64'h7000, 64'h70, -1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sysbus_arbiter.md
# sysbus_arbiter

Shares the single Sysbus master port between two requesters inside the core: the instruction-fetch unit (port `f_*`) and the data-memory unit (port `d_*`). It grants one whole transaction at a time with round-robin fairness. For writes it forwards the request beat plus all data beats; for reads it routes every response beat back to the requester that owns the transaction. Each requester sees a private Sysbus-style interface; the arbiter sits between those requesters and the top-level `Sysbus bus`.

## Interface
- `DATA_WIDTH`, 64, width of `req`/`resp` (address and data beats)
- `TAG_WIDTH`, 13, width of `reqtag`/`resptag`; bit `TAG_WIDTH-1` is the direction (1 = READ, 0 = WRITE)
- `BEATS`, 8, data beats per transaction (64-byte line)

Ports:
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `f_reqcyc` / `d_reqcyc`  in  1  requester drives a request or write-data beat
- `f_req` / `d_req`  in  DATA_WIDTH  address, then write data
- `f_reqtag` / `d_reqtag`  in  TAG_WIDTH  request tag
- `f_reqack` / `d_reqack`  out  1  request accepted
- `f_respcyc` / `d_respcyc`  out  1  response beat valid
- `f_resp` / `d_resp`  out  DATA_WIDTH  response data
- `f_resptag` / `d_resptag`  out  TAG_WIDTH  response tag
- `f_respack` / `d_respack`  in  1  requester consumes response beat
- `bus_reqcyc`, `bus_req`, `bus_reqtag`  out  1/DATA_WIDTH/TAG_WIDTH  to Sysbus
- `bus_reqack`  in  1  from Sysbus
- `bus_respcyc`, `bus_resp`, `bus_resptag`  in  1/DATA_WIDTH/TAG_WIDTH  from Sysbus
- `bus_respack`  out  1  to Sysbus
- `proto_err`  out  1  one-cycle pulse on an unexpected `bus_respcyc`

## Operation
- Registered state: `state` ∈ {IDLE, REQ, WDATA, RESP}, `owner` (0 = f, 1 = d), `last` (last granted), `is_write`, `beat` counter (`$clog2(BEATS)+1` bits).
- IDLE:
  - If exactly one `*_reqcyc` is high, grant it.
  - If both are high, grant the one ≠ `last`.
  - On grant: latch `owner`, set `last` = owner, latch `is_write` = ~owner_reqtag[TAG_WIDTH-1], go to REQ.
- REQ:
  - `bus_reqcyc/req/reqtag` = owner's inputs, combinationally.
  - Owner's `reqack` = `bus_reqack`.
  - On `bus_reqack`: write → WDATA with `beat`=0; read → RESP with `beat`=0.
- WDATA:
  - Owner's `reqcyc/req` pass through to the bus.
  - Count a beat when owner `reqcyc` is high.
  - After beat `BEATS-1` → IDLE. Writes have no response phase.
- RESP:
  - `bus_resp`/`bus_resptag` fan out to both requesters' data outputs.
  - Only the owner's `respcyc` = `bus_respcyc`.
  - `bus_respack` = owner's `respack`.
  - Count a beat on `bus_respcyc && respack`. After beat `BEATS-1` → IDLE.
- Non-owner: `reqack`=0 and `respcyc`=0 at all times.
- Non-REQ/WDATA states: `bus_reqcyc`=0, `bus_req`=0, `bus_reqtag`=0.
- `bus_respcyc` outside RESP: `bus_respack`=0, `proto_err` pulses the following cycle, state is unchanged.
- A requester that drops `reqcyc` while in REQ is not abandoned. The bus sees `reqcyc`=0 and the arbiter stays in REQ until `bus_reqack`.

## Timing
- Reset (asynchronous):
  - state=IDLE, `last`=d (so fetch wins the first tie), `beat`=0.
  - All outputs 0 immediately, without waiting for a clock.
- Reset asserted mid-transaction aborts it. No beats are forwarded after reset.
- Grant latency:
  - A request sampled high at edge N puts `bus_reqcyc` high in cycle N+1.
  - The ack is combinational (same cycle as `bus_reqack`).
- IDLE re-arbitrates on the edge after the last beat, so back-to-back transactions have a one-cycle IDLE gap.
- `beat` wraps only by leaving RESP/WDATA. No partial-line completion.

## Test plan
- Single read from f:
  - Stimulus: `f_reqcyc`=1, addr 0x1000, tag READ; ack in cycle 3; 8 resp beats 0x0..0x7.
  - Required: `f_resp` carries the beats in order, `d_respcyc` stays 0, state returns to IDLE after beat 7.
- Simultaneous f and d reads from reset:
  - Required: f is granted first, then d.
  - A second simultaneous pair grants d first (round-robin alternates).
- d write:
  - Stimulus: d write to 0x2000 followed by 8 data beats 0xA0..0xA7.
  - Required: `bus_req` shows 0x2000 then 0xA0..0xA7, there is no RESP phase, and an f request pending throughout is granted the cycle after the last beat.
- Response backpressure:
  - Stimulus: `f_respack` low for 3 cycles mid-burst.
  - Required: `bus_respack` low in those 3 cycles, beat count frozen, all 8 beats delivered exactly once.
- Stray response:
  - Stimulus: `bus_respcyc`=1 while IDLE.
  - Required: `proto_err` pulses once, `bus_respack`=0, no requester sees `respcyc`.
- Asynchronous reset:
  - Stimulus: reset asserted during RESP beat 4.
  - Required: all outputs 0 before the next clock edge; after deassert, a new f read completes normally with 8 beats.
